// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller side and the change dispenser.
interface change_dispenser_if;
  logic       load;
  logic [3:0] give;
  logic [7:0] change;
  logic [3:0] tube_empty;
  logic       product_ack;
  logic       coin_ack;
  logic       product_valid;
  logic [3:0] product_id;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic [7:0] coins_paid;
  logic       busy;
  logic       done;
  logic       fault;
  logic [7:0] shortfall;

  modport master (
    output load, give, change, tube_empty, product_ack, coin_ack,
    input  product_valid, product_id, coin_valid, coin_value, coins_paid,
           busy, done, fault, shortfall
  );

  modport slave (
    input  load, give, change, tube_empty, product_ack, coin_ack,
    output product_valid, product_id, coin_valid, coin_value, coins_paid,
           busy, done, fault, shortfall
  );
endinterface

// File: rtl/change_dispenser.sv
// Releases the purchased product, then pays change greedily (50/10/5/1) one coin
// per handshake, skipping empty tubes and flagging a fault when change cannot be paid.
module change_dispenser (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PROD, SEL, COIN, DONE, FAULT} state_e;

  state_e     state_q, state_d;
  logic [3:0] product_id_q, product_id_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] coin_value_q, coin_value_d;
  logic [7:0] coins_paid_q, coins_paid_d;
  logic [7:0] shortfall_q, shortfall_d;
  logic       fault_q, fault_d;
  logic       product_valid_q, product_valid_d;
  logic       coin_valid_q, coin_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] pick;

  // Largest coin that fits the remaining amount and has a non-empty tube; 0 if none.
  function automatic logic [7:0] pick_coin(input logic [7:0] rem, input logic [3:0] empty);
    if (!empty[3] && rem >= 8'd50) return 8'd50;
    if (!empty[2] && rem >= 8'd10) return 8'd10;
    if (!empty[1] && rem >= 8'd5)  return 8'd5;
    if (!empty[0] && rem >= 8'd1)  return 8'd1;
    return 8'd0;
  endfunction

  assign pick = pick_coin(remaining_q, bus.tube_empty);

  always_comb begin
    state_d      = state_q;
    product_id_d = product_id_q;
    remaining_d  = remaining_q;
    coin_value_d = coin_value_q;
    coins_paid_d = coins_paid_q;
    shortfall_d  = shortfall_q;
    fault_d      = fault_q;
    case (state_q)
      IDLE, FAULT: begin
        if (bus.load) begin
          product_id_d = bus.give;
          remaining_d  = bus.change;
          coins_paid_d = 8'd0;
          fault_d      = 1'b0;
          shortfall_d  = 8'd0;
          state_d      = (bus.give != 4'd0) ? PROD : SEL;
        end
      end
      PROD: if (bus.product_ack) state_d = SEL;
      SEL: begin
        if (remaining_q == 8'd0) begin
          state_d = DONE;
        end else if (pick != 8'd0) begin
          coin_value_d = pick;
          state_d      = COIN;
        end else begin
          fault_d     = 1'b1;
          shortfall_d = remaining_q;
          state_d     = FAULT;
        end
      end
      COIN: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - coin_value_q;
          if (coins_paid_q != 8'hFF) coins_paid_d = coins_paid_q + 8'd1;
          state_d = SEL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake/status outputs are registered from the next state so they align with it.
    product_valid_d = (state_d == PROD);
    coin_valid_d    = (state_d == COIN);
    busy_d          = (state_d inside {PROD, SEL, COIN, DONE});
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      product_id_q    <= 4'd0;
      remaining_q     <= 8'd0;
      coin_value_q    <= 8'd0;
      coins_paid_q    <= 8'd0;
      shortfall_q     <= 8'd0;
      fault_q         <= 1'b0;
      product_valid_q <= 1'b0;
      coin_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      product_id_q    <= product_id_d;
      remaining_q     <= remaining_d;
      coin_value_q    <= coin_value_d;
      coins_paid_q    <= coins_paid_d;
      shortfall_q     <= shortfall_d;
      fault_q         <= fault_d;
      product_valid_q <= product_valid_d;
      coin_valid_q    <= coin_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.product_valid = product_valid_q;
  assign bus.product_id    = product_id_q;
  assign bus.coin_valid    = coin_valid_q;
  assign bus.coin_value    = coin_value_q;
  assign bus.coins_paid    = coins_paid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.fault         = fault_q;
  assign bus.shortfall     = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized bench for change_dispenser; acts as product chute and coin ejector.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  change_dispenser_if bus();
  change_dispenser dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".product_valid"}, 32'(bus.product_valid), 32'(1'b0));
    chk({tag, ".product_id"},    32'(bus.product_id),    32'(4'd0));
    chk({tag, ".coin_valid"},    32'(bus.coin_valid),    32'(1'b0));
    chk({tag, ".coin_value"},    32'(bus.coin_value),    32'(8'd0));
    chk({tag, ".coins_paid"},    32'(bus.coins_paid),    32'(8'd0));
    chk({tag, ".busy"},          32'(bus.busy),          32'(1'b0));
    chk({tag, ".done"},          32'(bus.done),          32'(1'b0));
    chk({tag, ".fault"},         32'(bus.fault),         32'(1'b0));
    chk({tag, ".shortfall"},     32'(bus.shortfall),     32'(8'd0));
  endtask

  // One transaction; the reference payout is greedy change-making by division.
  task automatic run_txn(input logic [3:0] g, input logic [7:0] c, input logic [3:0] te,
                         input bit tied, input int pd, input bit inject);
    int  den [4] = '{50, 10, 5, 1};
    int  exp_q[$];
    int  got_q[$];
    int  rem, cyc, pcnt, ccnt, pdly, cdly, n_exp;
    bit  prod_taken, finished, inject_done, have_prev, pa, ca, exp_fault;
    logic [7:0] prev_coin;

    rem = c;
    for (int i = 0; i < 4; i++) begin
      if (!te[3-i]) begin
        int n;
        n = rem / den[i];
        repeat (n) exp_q.push_back(den[i]);
        rem = rem % den[i];
      end
    end
    exp_fault = (rem != 0);
    n_exp     = exp_q.size();

    pdly = tied ? 1 : ((pd > 0) ? pd : int'($urandom_range(1, 4)));
    cdly = tied ? 1 : int'($urandom_range(1, 3));

    @(negedge clk);
    bus.give        = g;
    bus.change      = c;
    bus.tube_empty  = te;
    bus.load        = 1'b1;
    bus.product_ack = tied;
    bus.coin_ack    = tied;
    tick();
    bus.load = 1'b0;
    chk("load.busy",       32'(bus.busy),       32'(1'b1));
    chk("load.done",       32'(bus.done),       32'(1'b0));
    chk("load.fault",      32'(bus.fault),      32'(1'b0));
    chk("load.shortfall",  32'(bus.shortfall),  32'(8'd0));
    chk("load.coins_paid", 32'(bus.coins_paid), 32'(8'd0));

    cyc = 1; pcnt = 0; ccnt = 0;
    prod_taken = (g == 4'd0);
    finished = 1'b0; inject_done = 1'b0; have_prev = 1'b0;
    prev_coin = 8'd0;
    while (cyc < 4000) begin
      if (bus.done || bus.fault) begin
        finished = 1'b1;
        break;
      end
      if (!prod_taken) begin
        chk("product_valid_held",     32'(bus.product_valid), 32'(1'b1));
        chk("product_id",             32'(bus.product_id),    32'(g));
        chk("no_coin_before_product", 32'(bus.coin_valid),    32'(1'b0));
      end else begin
        chk("product_released", 32'(bus.product_valid), 32'(1'b0));
      end
      if (bus.coin_valid && have_prev) begin
        chk("coin_value_stable", 32'(bus.coin_value), 32'(prev_coin));
      end

      if (bus.product_valid) pcnt++;
      pa = tied || (bus.product_valid && pcnt >= pdly);
      if (bus.product_valid && pa) prod_taken = 1'b1;

      if (bus.coin_valid) ccnt++;
      ca = tied || (bus.coin_valid && ccnt >= cdly);
      if (bus.coin_valid && ca) begin
        got_q.push_back(int'(bus.coin_value));
        ccnt = 0;
        have_prev = 1'b0;
        cdly = tied ? 1 : int'($urandom_range(1, 3));
      end else if (bus.coin_valid) begin
        have_prev = 1'b1;
        prev_coin = bus.coin_value;
      end

      if (inject && bus.coin_valid && !inject_done) begin
        bus.load    = 1'b1;
        bus.change  = 8'd99;
        inject_done = 1'b1;
      end
      bus.product_ack = pa;
      bus.coin_ack    = ca;
      tick();
      bus.load = 1'b0;
      cyc++;
    end

    chk("completed_in_budget", 32'(finished), 32'(1'b1));
    chk("coin_count", 32'(got_q.size()), 32'(n_exp));
    for (int i = 0; i < got_q.size() && i < n_exp; i++) begin
      chk("coin_sequence", 32'(got_q[i]), 32'(exp_q[i]));
    end
    chk("coins_paid", 32'(bus.coins_paid), 32'(n_exp));
    chk("fault_flag", 32'(bus.fault),      32'(exp_fault));
    chk("done_flag",  32'(bus.done),       32'(!exp_fault));
    if (exp_fault) begin
      chk("fault.shortfall", 32'(bus.shortfall), 32'(rem));
      chk("fault.busy",      32'(bus.busy),      32'(1'b0));
      bus.product_ack = 1'b1;
      bus.coin_ack    = 1'b1;
      repeat (3) tick();
      chk("fault_hold.fault",      32'(bus.fault),         32'(1'b1));
      chk("fault_hold.shortfall",  32'(bus.shortfall),     32'(rem));
      chk("fault_hold.busy",       32'(bus.busy),          32'(1'b0));
      chk("fault_hold.coin_valid", 32'(bus.coin_valid),    32'(1'b0));
      chk("fault_hold.prod_valid", 32'(bus.product_valid), 32'(1'b0));
    end else begin
      chk("done.busy", 32'(bus.busy), 32'(1'b1));
      if (tied) begin
        chk("done_latency", 32'(cyc), 32'(2 * n_exp + 2 + ((g != 4'd0) ? 1 : 0)));
      end
      tick();
      chk("after_done.done", 32'(bus.done), 32'(1'b0));
      chk("after_done.busy", 32'(bus.busy), 32'(1'b0));
    end
    bus.product_ack = 1'b0;
    bus.coin_ack    = 1'b0;
  endtask

  initial begin
    reset           = 1'b0;
    bus.load        = 1'b0;
    bus.give        = 4'd0;
    bus.change      = 8'd0;
    bus.tube_empty  = 4'd0;
    bus.product_ack = 1'b0;
    bus.coin_ack    = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    run_txn(4'd0, 8'd17, 4'b0000, 1'b1, 0, 1'b0);
    run_txn(4'd3, 8'd9,  4'b0000, 1'b0, 3, 1'b0);
    run_txn(4'd0, 8'd60, 4'b1000, 1'b1, 0, 1'b0);
    run_txn(4'd0, 8'd7,  4'b0001, 1'b1, 0, 1'b0);
    run_txn(4'd0, 8'd0,  4'b0000, 1'b1, 0, 1'b0);
    run_txn(4'd0, 8'd1,  4'b0000, 1'b1, 0, 1'b0);
    run_txn(4'd2, 8'd40, 4'b0000, 1'b1, 0, 1'b1);

    // Reset while a coin is on offer.
    @(negedge clk);
    bus.give       = 4'd0;
    bus.change     = 8'd50;
    bus.tube_empty = 4'b0000;
    bus.load       = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 10 && !bus.coin_valid; i++) tick();
    chk("rst_mid.coin_offered", 32'(bus.coin_valid), 32'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    run_txn(4'd4, 8'd33, 4'b0000, 1'b0, 0, 1'b0);

    for (int k = 0; k < 25; k++) begin
      logic [3:0] g, te;
      logic [7:0] c;
      g  = 4'($urandom_range(0, 4));
      c  = 8'($urandom_range(0, 255));
      te = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      run_txn(g, c, te, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Output stage that sits directly downstream of the `AutoVendor` controller. It accepts one settled transaction: a product code and a change amount in dollars. It first releases the product to the product chute, then pays the change as a sequence of physical coins (50/10/5/1), one coin per handshake. Denominations are chosen greedily and any empty coin tube is skipped. A fault is reported if the remaining change cannot be paid.

## Interface
Parameters: none. Denominations are fixed at 50, 10, 5 and 1.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `load`  input  1  transaction strobe, one cycle wide, sampled at the clock edge.
- `give`  input  4  product code from the controller (0 = none, 1 tea, 2 cola, 3 coffee, 4 milk).
- `change`  input  8  change amount in dollars, unsigned, range 0–255.
- `tube_empty`  input  4  coin tube empty flags: [3]=50, [2]=10, [1]=5, [0]=1.
- `product_ack`  input  1  product chute has taken the product.
- `coin_ack`  input  1  coin ejector has taken the current coin.
- `product_valid`  output  1  a product is being offered.
- `product_id`  output  4  the offered product code.
- `coin_valid`  output  1  a coin is being offered.
- `coin_value`  output  8  value of the offered coin (50, 10, 5 or 1).
- `coins_paid`  output  8  number of coins paid in the current transaction.
- `busy`  output  1  a transaction is in progress.
- `done`  output  1  one-cycle pulse when the transaction completes.
- `fault`  output  1  change could not be paid.
- `shortfall`  output  8  unpaid amount when `fault` is high.

## Operation
- Internal register `remaining` is 8 bits wide.
- States: IDLE, PROD, SEL, COIN, DONE, FAULT.
- **IDLE / FAULT:**
  - `load`=1 latches `give` and `change` into `remaining` and clears `coins_paid`, `fault` and `shortfall`.
  - Next state is PROD if `give`≠0, otherwise SEL.
- **PROD:**
  - `product_valid`=1 and `product_id`=latched `give`; both are held stable until `product_ack`=1 is sampled.
  - On `product_ack`: `product_valid` drops and the next state is SEL.
- **SEL:**
  - If `remaining`=0, go to DONE.
  - Otherwise pick the largest d in {50,10,5,1} with d ≤ `remaining` whose tube is not empty. Load it into `coin_value` and go to COIN.
  - If no such d exists, go to FAULT with `shortfall`=`remaining`.
- **COIN:**
  - `coin_valid`=1; `coin_value` is stable until `coin_ack`=1 is sampled.
  - On `coin_ack`: `remaining` -= `coin_value`, `coins_paid` += 1 (saturating at 255), `coin_valid` drops, next state is SEL.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- **FAULT:**
  - `fault`=1 and `shortfall` are held until the next accepted `load`.
  - No product or coin is offered while in FAULT.
- `busy`=1 in PROD, SEL, COIN and DONE; 0 in IDLE and FAULT.
- `load` is ignored in PROD, SEL, COIN and DONE.
- `tube_empty` is sampled only in SEL. A tube emptying while its coin is already being offered does not withdraw that coin.
- `product_ack` outside PROD and `coin_ack` outside COIN are ignored.
- Greedy subtraction cannot underflow because d ≤ `remaining` is guaranteed by SEL.

## Timing
- Reset (`reset`=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: `product_valid`, `product_id`, `coin_valid`, `coin_value`, `coins_paid`, `busy`, `done`, `fault`, `shortfall`.
  - Reset takes effect mid-transaction too; an offered coin or product is withdrawn at that edge.
- All outputs are registered.
- `load` at edge N gives `busy`=1 from N+1.
- With an immediate ack, each coin costs 2 cycles (SEL then COIN).
- Example, `give`=0, `change`=0: SEL at N+1, DONE at N+2 with `done`=1, IDLE at N+3.
- Example, `give`=0, `change`=1, acks tied high: SEL at N+1, COIN at N+2, SEL at N+3, DONE at N+4.
- The product is always delivered before any coin.
- Acks may stay high continuously. A single ack completes only one offer, since the valid signal drops on the following cycle.

## Test plan
- `give`=0, `change`=17, all tubes full, acks tied to 1 → coins 10, 5, 1, 1 in that order; `coins_paid`=4; one `done` pulse; `busy` back to 0.
- `give`=3, `change`=9, `product_ack` delayed 3 cycles → `product_valid`/`product_id`=3 held for 3 cycles; then coins 5, 1, 1, 1, 1; no coin is offered before `product_ack`.
- `change`=60, `tube_empty`=4'b1000 → six 10-coins; `coins_paid`=6; `fault` stays 0.
- `change`=7, `tube_empty`=4'b0001 → one 5-coin, then FAULT with `fault`=1, `shortfall`=2, `busy`=0. A new `load` with `change`=0 clears `fault`.
- `load` during COIN with `change`=99 → ignored; the original payout completes unchanged.
- `reset` driven to 0 while `coin_valid`=1 → every output is 0 at the next edge; the following `load` runs normally.
